// File: rtl/alu_serial.sv
// Serial ALU: WIDTH-bit operands processed one 4-bit slice per cycle, LSB first,
// with carry chained between slices; valid/ready handshakes on both sides.
module alu_serial #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags
);
  localparam int unsigned N  = WIDTH / 4;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam int unsigned FC = 0;
  localparam int unsigned FH = 1;
  localparam int unsigned FN = 2;
  localparam int unsigned FZ = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_SBC = 4'd3,
    OP_AND = 4'd4,
    OP_XOR = 4'd5,
    OP_OR  = 4'd6,
    OP_CP  = 4'd7,
    OP_INC = 4'd8,
    OP_DEC = 4'd9,
    OP_DAA = 4'd10,
    OP_CPL = 4'd11,
    OP_SCF = 4'd12,
    OP_CCF = 4'd13
  } op_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  op_e              op_q;
  logic [WIDTH-1:0] a_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] x_sh, y_sh;
  logic [WIDTH-5:0] res_sh;
  logic             carry_q;
  logic             daa_hi_q;

  logic [WIDTH-1:0] dec_x, dec_y, corr;
  logic             dec_cin, daa_lo, daa_hi;
  logic [7:0]       a_lo8;

  logic [4:0]       slice_sum;
  logic [WIDTH-1:0] full_res;
  logic [WIDTH-1:0] fin_result;
  logic [3:0]       fin_flags;
  logic             z_res, c_top, h_top;

  // Every op is reduced at accept to x + y + cin; logic/copy ops precompute x and add zero.
  always_comb begin
    a_lo8   = in_a[7:0];
    daa_lo  = in_flags[FH] || (!in_flags[FN] && (a_lo8[3:0] > 4'd9));
    daa_hi  = in_flags[FC] || (!in_flags[FN] && (a_lo8 > 8'h99));
    corr    = '0;
    dec_x   = in_a;
    dec_y   = '0;
    dec_cin = 1'b0;
    case (op_e'(in_op))
      OP_ADD: dec_y = in_b;
      OP_ADC: begin
        dec_y   = in_b;
        dec_cin = in_flags[FC];
      end
      OP_SUB, OP_CP: begin
        dec_y   = ~in_b;
        dec_cin = 1'b1;
      end
      OP_SBC: begin
        dec_y   = ~in_b;
        dec_cin = ~in_flags[FC];
      end
      OP_INC: begin
        dec_x   = in_b;
        dec_cin = 1'b1;
      end
      OP_DEC: begin
        dec_x = in_b;
        dec_y = '1;
      end
      OP_AND: dec_x = in_a & in_b;
      OP_XOR: dec_x = in_a ^ in_b;
      OP_OR:  dec_x = in_a | in_b;
      OP_CPL: dec_x = ~in_a;
      OP_DAA: begin
        if (WIDTH == 8) begin
          corr[7:0] = {(daa_hi ? 4'h6 : 4'h0), (daa_lo ? 4'h6 : 4'h0)};
          if (in_flags[FN]) begin
            dec_y   = ~corr;
            dec_cin = 1'b1;
          end else begin
            dec_y = corr;
          end
        end
      end
      default: ;
    endcase
  end

  assign slice_sum = {1'b0, x_sh[3:0]} + {1'b0, y_sh[3:0]} + {4'b0, carry_q};
  assign full_res  = {slice_sum[3:0], res_sh};

  // On the last slice carry_q still holds the carry into the top slice (H source).
  always_comb begin
    c_top      = slice_sum[4];
    h_top      = carry_q;
    z_res      = (full_res == '0);
    fin_result = full_res;
    fin_flags  = flags_q;
    case (op_q)
      OP_ADD, OP_ADC: fin_flags = {z_res, 1'b0, h_top, c_top};
      OP_SUB, OP_SBC: fin_flags = {z_res, 1'b1, ~h_top, ~c_top};
      OP_CP: begin
        fin_flags  = {z_res, 1'b1, ~h_top, ~c_top};
        fin_result = a_q;
      end
      OP_INC: fin_flags = {z_res, 1'b0, h_top, flags_q[FC]};
      OP_DEC: fin_flags = {z_res, 1'b1, ~h_top, flags_q[FC]};
      OP_AND: fin_flags = {z_res, 1'b0, 1'b1, 1'b0};
      OP_XOR, OP_OR: fin_flags = {z_res, 1'b0, 1'b0, 1'b0};
      OP_CPL: fin_flags = {flags_q[FZ], 1'b1, 1'b1, flags_q[FC]};
      OP_SCF: fin_flags = {flags_q[FZ], 1'b0, 1'b0, 1'b1};
      OP_CCF: fin_flags = {flags_q[FZ], 1'b0, 1'b0, ~flags_q[FC]};
      OP_DAA: begin
        if (WIDTH == 8) begin
          fin_flags = {z_res, flags_q[FN], 1'b0, daa_hi_q};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_BUSY;
      S_BUSY: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      op_q       <= OP_ADD;
      a_q        <= '0;
      flags_q    <= '0;
      x_sh       <= '0;
      y_sh       <= '0;
      res_sh     <= '0;
      carry_q    <= 1'b0;
      daa_hi_q   <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
    end else if (state_q == S_IDLE && in_valid) begin
      cnt_q    <= '0;
      op_q     <= op_e'(in_op);
      a_q      <= in_a;
      flags_q  <= in_flags;
      x_sh     <= dec_x;
      y_sh     <= dec_y;
      carry_q  <= dec_cin;
      daa_hi_q <= daa_hi;
    end else if (state_q == S_BUSY) begin
      x_sh    <= x_sh >> 4;
      y_sh    <= y_sh >> 4;
      res_sh  <= full_res[WIDTH-1:4];
      carry_q <= slice_sum[4];
      if (cnt_q == LAST) begin
        cnt_q      <= '0;
        out_result <= fin_result;
        out_flags  <= fin_flags;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
